uart_rx_comando: RTL and testbench
==================================

# uart_rx_comando

Serial receiver feeding the command handler: deserializes 8N1 UART frames from the host and presents each byte as a 4-bit instruction (high nibble) and a 4-bit data value (low nibble). The instruction is presented for `HOLD_CYCLES` cycles and then returns to 0, the no-op code, so the command handler acts on each received command exactly once. The block sits between the board RX pin and the command handler's `instrucao`/`dado` inputs.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range ≥ 4.
- `HOLD_CYCLES`, default 4: cycles `instrucao` holds a received code before reverting to 0; legal range ≥ 1.
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `instrucao`  out  4  received byte bits [7:4] for `HOLD_CYCLES` cycles, otherwise 0.
- `dado`  out  4  received byte bits [3:0]; holds until the next valid frame.
- `valido`  out  1  one-cycle pulse when a new valid frame is loaded.
- `erro_quadro`  out  1  one-cycle pulse on a framing error (stop bit sampled 0).
- `ocupado`  out  1  high while a frame is in progress (state ≠ OCIOSO).

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- States: OCIOSO, INICIO, DADOS, PARADA, ESPERA_ALTO.
- **OCIOSO**
  - Synchronized `rx` == 0 → INICIO, with the baud counter cleared.
  - A line held low out of reset is not a start. A start requires a prior sampled 1, which the synchronizer's reset value of 1 provides.
- **INICIO**
  - At count `CLKS_PER_BIT/2 − 1` (integer division), resample the line.
  - Line is 0 → DADOS, with the bit index set to 0.
  - Line is 1 → false start; return to OCIOSO with no output pulse.
- **DADOS**
  - Sample every `CLKS_PER_BIT` cycles, mid-bit.
  - Bits arrive LSB first into an 8-bit shift register.
  - After the sample at bit index 7 → PARADA.
- **PARADA**
  - Sample the stop bit at mid-bit.
  - Sample is 1: load `dado` ← byte[3:0] and `instrucao` ← byte[7:4], load the hold counter with `HOLD_CYCLES`, pulse `valido`, then → OCIOSO.
  - Sample is 0: pulse `erro_quadro` and leave `dado`/`instrucao` untouched, then → ESPERA_ALTO.
- **ESPERA_ALTO**
  - Stay until synchronized `rx` == 1, then → OCIOSO.
  - This prevents a break condition from being decoded as a stream of frames.
- **Hold counter**
  - Decrements each cycle while nonzero.
  - `instrucao` is forced to 0 on the cycle the counter reaches 0.
  - A new valid frame arriving during the hold reloads the counter and the outputs.
- Widths: baud counter `$clog2(CLKS_PER_BIT)` bits; bit index 3 bits; hold counter `$clog2(HOLD_CYCLES+1)` bits. No counter may wrap inside a state.

## Timing
- Reset values:
  - outputs: `instrucao`=0, `dado`=0, `valido`=0, `erro_quadro`=0, `ocupado`=0.
  - internal: state OCIOSO, all counters 0.
- Reset asserted mid-frame aborts immediately. No pulses are issued, and the partial byte is discarded.
- Latency:
  - `valido` and the new `instrucao`/`dado` appear 1 cycle after the mid-stop-bit sample.
  - That is ≈ 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles after the falling start edge at the pin.
- `instrucao` is nonzero for exactly `HOLD_CYCLES` cycles, starting in the same cycle as `valido`.
- Back-to-back frames: returning to OCIOSO at mid-stop allows a start edge at the following bit boundary to be caught.
- `valido` and `erro_quadro` are never high in the same cycle.

## Structure
- Shared package `comando_pkg`:
  - command codes: NOP=0, LIMPAR=1, CARREGAR=2, MOSTRAR=4. These are shared with the command handler.
  - the receiver state enum.
- One sub-module, `sincronizador`: the 2-flop synchronizer, with a reset value parameter.

## Test plan
All scenarios run with `CLKS_PER_BIT`=8 and `HOLD_CYCLES`=4.
- Reset held, `rx`=1, then released → all outputs 0; `ocupado`=0.
- Frame 0x2A with a good stop bit → one `valido` pulse; `dado`=0xA; `instrucao`=0x2 for 4 cycles, then 0; `dado` stays 0xA.
- Frames 0x13 then 0x4F sent back-to-back with no idle → two `valido` pulses; `dado` ends 0x3 then 0xF; `instrucao` shows 1 then 4.
- Frame 0x27 with stop bit 0 and line held low for 3 bit times → one `erro_quadro` pulse, no `valido`, `dado` unchanged, no further activity until `rx` goes high.
- Low glitch of 2 cycles on `rx` → false start; no pulses; `ocupado` drops within `CLKS_PER_BIT/2`+3 cycles.
- Reset pulsed at data bit 4 of frame 0x11, with the remainder of that frame discarded, then frame 0x22 → only one `valido`, for 0x22 (`instrucao`=2, `dado`=2).

Source files
------------

// File: rtl/comando_pkg.sv
// Definitions shared by the UART command receiver and the command handler:
// instruction codes and the receiver state encoding.
package comando_pkg;

    localparam logic [3:0] CMD_NOP      = 4'h0;
    localparam logic [3:0] CMD_LIMPAR   = 4'h1;
    localparam logic [3:0] CMD_CARREGAR = 4'h2;
    localparam logic [3:0] CMD_MOSTRAR  = 4'h4;

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARADA,
        ESPERA_ALTO
    } rxEstado_t;

endpackage

// File: rtl/uart_rx_comando_sincronizador.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to RESET_VAL
// so an idle-high line never looks like an edge when reset is released.
module sincronizador #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_comando.sv
// 8N1 UART receiver that splits each byte into a held instruction nibble and a data nibble
// for the command handler; the instruction reverts to NOP after HOLD_CYCLES cycles.
module uart_rx_comando
    import comando_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HOLD_CYCLES  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] instrucao,
    output logic [3:0] dado,
    output logic       valido,
    output logic       erro_quadro,
    output logic       ocupado
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [CW-1:0] BIT_FIM    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MEIO_FIM   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [HW-1:0] HOLD_CARGA = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_UM    = HW'(1);

    logic            w_rx;
    rxEstado_t       r_estado;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [HW-1:0]   r_hold;
    logic [3:0]      r_instrucao;
    logic [3:0]      r_dado;
    logic            r_valido;
    logic            r_erro;
    logic            r_ocupado;

    sincronizador #(
        .RESET_VAL (1'b1)
    ) uSinc (
        .clock (clock),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx)
    );

    // Frame FSM plus hold counter; a frame load in PARADA overrides the hold countdown.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_instrucao <= CMD_NOP;
            r_dado      <= '0;
            r_valido    <= 1'b0;
            r_erro      <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            r_erro   <= 1'b0;

            if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_UM;
                if (r_hold == HOLD_UM) begin
                    r_instrucao <= CMD_NOP;
                end
            end

            case (r_estado)
                OCIOSO: begin
                    if (!w_rx) begin
                        r_estado  <= INICIO;
                        r_cnt     <= '0;
                        r_ocupado <= 1'b1;
                    end
                end
                INICIO: begin
                    if (r_cnt == MEIO_FIM) begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_estado <= DADOS;
                            r_idx    <= '0;
                        end else begin
                            r_estado  <= OCIOSO;
                            r_ocupado <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DADOS: begin
                    if (r_cnt == BIT_FIM) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_estado <= PARADA;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARADA: begin
                    if (r_cnt == BIT_FIM) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_dado      <= r_shift[3:0];
                            r_instrucao <= r_shift[7:4];
                            r_hold      <= HOLD_CARGA;
                            r_valido    <= 1'b1;
                            r_estado    <= OCIOSO;
                            r_ocupado   <= 1'b0;
                        end else begin
                            r_erro   <= 1'b1;
                            r_estado <= ESPERA_ALTO;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // A held-low line (break) parks here so it is not decoded as frames.
                ESPERA_ALTO: begin
                    if (w_rx) begin
                        r_estado  <= OCIOSO;
                        r_ocupado <= 1'b0;
                    end
                end
                default: begin
                    r_estado  <= OCIOSO;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign instrucao   = r_instrucao;
    assign dado        = r_dado;
    assign valido      = r_valido;
    assign erro_quadro = r_erro;
    assign ocupado     = r_ocupado;

endmodule

// File: tb/tb_uart_rx_comando.sv
// Directed and randomized frames for uart_rx_comando, checked against a byte-level
// model of what the host sent.
module tb_uart_rx_comando;

    localparam int CPB  = 8;
    localparam int HOLD = 4;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [3:0] instrucao;
    logic [3:0] dado;
    logic       valido;
    logic       erro_quadro;
    logic       ocupado;

    int nAssert = 0;
    int nFail   = 0;

    int validoCount   = 0;
    int erroCount     = 0;
    int bothHigh      = 0;
    int runLen        = 0;
    int lastRun       = 0;
    int ocupadoCycles = 0;
    logic [7:0] obsQ[$];
    int qi = 0;

    uart_rx_comando #(
        .CLKS_PER_BIT (CPB),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .instrucao   (instrucao),
        .dado        (dado),
        .valido      (valido),
        .erro_quadro (erro_quadro),
        .ocupado     (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observes the outputs away from the active edge and records received bytes and pulse counts.
    always @(negedge clock) begin
        if (!reset) begin
            if (valido) begin
                validoCount++;
                obsQ.push_back({instrucao, dado});
            end
            if (erro_quadro) erroCount++;
            if (valido && erro_quadro) bothHigh++;
            if (ocupado) ocupadoCycles++;
            if (instrucao != 4'h0) begin
                runLen++;
            end else if (runLen != 0) begin
                lastRun = runLen;
                runLen  = 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkNextByte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (qi < obsQ.size()) ? obsQ[qi] : 8'hxx;
        qi++;
        checkOutput(tag, {24'h0, got}, {24'h0, exp});
    endtask

    // One 8N1 frame, LSB first, each bit held CPB cycles starting on a falling clock edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clock);
    endtask

    initial begin
        int v0;
        int e0;
        int o0;
        logic [7:0] b;
        logic [7:0] expQ[$];
        logic [7:0] frame11;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        $display("[TB] reset state");
        checkOutput("reset_instrucao", {28'h0, instrucao}, 32'h0);
        checkOutput("reset_dado", {28'h0, dado}, 32'h0);
        checkOutput("reset_valido", {31'h0, valido}, 32'h0);
        checkOutput("reset_erro", {31'h0, erro_quadro}, 32'h0);
        checkOutput("reset_ocupado", {31'h0, ocupado}, 32'h0);

        $display("[TB] single frame 0x2A");
        v0 = validoCount;
        e0 = erroCount;
        applyStimulus(8'h2A, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        checkOutput("f2A_valido_count", validoCount - v0, 32'd1);
        checkNextByte("f2A_byte_at_valido", 8'h2A);
        checkOutput("f2A_instr_hold_len", lastRun, HOLD);
        checkOutput("f2A_instr_after_hold", {28'h0, instrucao}, 32'h0);
        checkOutput("f2A_dado_kept", {28'h0, dado}, 32'hA);
        checkOutput("f2A_no_erro", erroCount - e0, 32'd0);

        $display("[TB] back-to-back 0x13 0x4F");
        v0 = validoCount;
        applyStimulus(8'h13, 1'b1);
        applyStimulus(8'h4F, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        checkOutput("b2b_valido_count", validoCount - v0, 32'd2);
        checkNextByte("b2b_first_byte", 8'h13);
        checkNextByte("b2b_second_byte", 8'h4F);
        checkOutput("b2b_dado_final", {28'h0, dado}, 32'hF);
        checkOutput("b2b_instr_hold_len", lastRun, HOLD);

        $display("[TB] framing error 0x27 then break");
        v0 = validoCount;
        e0 = erroCount;
        applyStimulus(8'h27, 1'b0);
        repeat (3 * CPB) @(negedge clock);
        checkOutput("ferr_erro_count", erroCount - e0, 32'd1);
        checkOutput("ferr_no_valido", validoCount - v0, 32'd0);
        checkOutput("ferr_dado_unchanged", {28'h0, dado}, 32'hF);
        checkOutput("ferr_instr_nop", {28'h0, instrucao}, 32'h0);
        checkOutput("ferr_busy_while_low", {31'h0, ocupado}, 32'h1);
        rx = 1'b1;
        repeat (CPB) @(negedge clock);
        checkOutput("ferr_idle_after_high", {31'h0, ocupado}, 32'h0);
        checkOutput("ferr_no_more_erro", erroCount - e0, 32'd1);
        checkOutput("ferr_no_more_valido", validoCount - v0, 32'd0);

        $display("[TB] glitch false start");
        v0 = validoCount;
        e0 = erroCount;
        o0 = ocupadoCycles;
        rx = 1'b0;
        repeat (2) @(negedge clock);
        rx = 1'b1;
        repeat (CPB / 2 + 1) @(negedge clock);
        checkOutput("glitch_ocupado_dropped", {31'h0, ocupado}, 32'h0);
        checkOutput("glitch_was_busy", {31'h0, (ocupadoCycles - o0) > 0}, 32'h1);
        repeat (2 * CPB) @(negedge clock);
        checkOutput("glitch_no_valido", validoCount - v0, 32'd0);
        checkOutput("glitch_no_erro", erroCount - e0, 32'd0);

        $display("[TB] reset mid-frame 0x11 then 0x22");
        v0 = validoCount;
        e0 = erroCount;
        frame11 = 8'h11;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = frame11[i];
            repeat (CPB) @(negedge clock);
        end
        rx = frame11[4];
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst_mid_ocupado", {31'h0, ocupado}, 32'h0);
        rx    = 1'b1;
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clock);
        checkOutput("rst_mid_no_valido", validoCount - v0, 32'd0);
        checkOutput("rst_mid_no_erro", erroCount - e0, 32'd0);
        applyStimulus(8'h22, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        checkOutput("rst_after_valido_count", validoCount - v0, 32'd1);
        checkNextByte("rst_after_byte", 8'h22);
        checkOutput("rst_after_dado", {28'h0, dado}, 32'h2);

        $display("[TB] random frames");
        v0 = validoCount;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom_range(0, 255));
            expQ.push_back(b);
            applyStimulus(b, 1'b1);
            repeat ($urandom_range(0, 3) * CPB) @(negedge clock);
        end
        repeat (2 * CPB) @(negedge clock);
        checkOutput("rand_valido_count", validoCount - v0, expQ.size());
        foreach (expQ[k]) begin
            checkNextByte($sformatf("rand_byte_%0d", k), expQ[k]);
        end
        checkOutput("rand_dado_final", {28'h0, dado}, {28'h0, expQ[expQ.size() - 1][3:0]});
        checkOutput("rand_instr_nop_after", {28'h0, instrucao}, 32'h0);

        checkOutput("never_valido_and_erro", bothHigh, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
